// File: rtl/reg_dump_unit_pkg.sv
// Shared debug definitions for the register-dump sequencer: word/select widths
// and the sequencer state encoding.
package reg_dump_unit_pkg;

    localparam int DBG_WORD_W = 32;
    localparam int DBG_SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        SEND = 2'd2
    } dump_state_e;

endpackage

// File: rtl/reg_dump_unit.sv
// Debug register-dump sequencer: snapshots the instruction word plus R0..NREGS-1
// through the processor debug port and streams them out as a valid/ready frame.
module reg_dump_unit
    import reg_dump_unit_pkg::*;
#(
    parameter int NREGS  = 16,
    parameter bit HDR_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DBG_WORD_W-1:0] DBtheRegVal,
    input  logic [DBG_WORD_W-1:0] machineValue,
    output logic [DBG_SEL_W-1:0]  DBtheReg,
    output logic [DBG_WORD_W-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  halt_req
);

    localparam logic [DBG_SEL_W-1:0] LAST_IDX = DBG_SEL_W'(NREGS - 1);

    dump_state_e           r_state;
    logic [DBG_SEL_W-1:0]  r_idx;
    logic [DBG_WORD_W-1:0] r_data;
    logic                  r_valid;
    logic                  r_last;
    logic                  r_busy;
    logic                  r_hdr;

    logic w_fire;
    logic w_at_last;

    assign w_fire    = r_valid && out_ready;
    assign w_at_last = (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_hdr   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx  <= '0;
                        r_busy <= 1'b1;
                        if (HDR_EN) begin
                            r_data  <= machineValue;
                            r_hdr   <= 1'b1;
                            r_valid <= 1'b1;
                            r_last  <= 1'b0;
                            r_state <= SEND;
                        end else begin
                            r_state <= SEL;
                        end
                    end
                end
                SEL: begin
                    // The debug port has had a full cycle to settle on r_idx.
                    r_data  <= DBtheRegVal;
                    r_valid <= 1'b1;
                    r_last  <= w_at_last;
                    r_state <= SEND;
                end
                SEND: begin
                    if (w_fire) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        if (r_hdr) begin
                            r_hdr   <= 1'b0;
                            r_state <= SEL;
                        end else if (w_at_last) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= SEL;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_hdr   <= 1'b0;
                end
            endcase
        end
    end

    assign DBtheReg  = r_idx;
    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign busy      = r_busy;
    assign halt_req  = r_busy;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Bench for reg_dump_unit: directed frames with randomized register contents and
// consumer backpressure, checked against an expected-word queue per frame.
module tb_reg_dump_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_a, start_b;
    logic        out_ready;
    logic        corrupt;
    logic [31:0] machine_value;
    logic [31:0] regs [16];

    logic [3:0]  a_sel,  b_sel;
    logic [31:0] a_data, b_data, a_rval, b_rval;
    logic        a_valid, a_last, a_busy, a_halt;
    logic        b_valid, b_last, b_busy, b_halt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Processor debug port model; corrupt scrambles it while a word is being sent.
    assign a_rval = corrupt ? 32'hDEAD_BEEF : regs[a_sel];
    assign b_rval = corrupt ? 32'hDEAD_BEEF : regs[b_sel];

    reg_dump_unit #(.NREGS(16), .HDR_EN(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a),
        .DBtheRegVal(a_rval), .machineValue(machine_value),
        .DBtheReg(a_sel), .out_data(a_data), .out_valid(a_valid),
        .out_ready(out_ready), .out_last(a_last), .busy(a_busy), .halt_req(a_halt)
    );

    reg_dump_unit #(.NREGS(4), .HDR_EN(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b),
        .DBtheRegVal(b_rval), .machineValue(machine_value),
        .DBtheReg(b_sel), .out_data(b_data), .out_valid(b_valid),
        .out_ready(out_ready), .out_last(b_last), .busy(b_busy), .halt_req(b_halt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic get_out(input bit b, output logic [3:0] s, output logic [31:0] d,
                           output logic v, output logic l, output logic bz, output logic h);
        if (b) begin
            s = b_sel; d = b_data; v = b_valid; l = b_last; bz = b_busy; h = b_halt;
        end else begin
            s = a_sel; d = a_data; v = a_valid; l = a_last; bz = a_busy; h = a_halt;
        end
    endtask

    task automatic randomize_regs();
        machine_value = $urandom;
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
    endtask

    task automatic run_frame(input bit b, input int nregs, input bit hdr, input int stall_word,
                             input bit rand_ready, input bit spam_start, input int exp_cycles);
        logic [31:0] exp_q[$];
        logic [3:0]  s, ps;
        logic [31:0] d, pd;
        logic        v, l, bz, h, pl;
        logic        pv, prdy;
        int          total, widx, k, stall_cnt, first_k;
        bit          done;
        if (hdr) exp_q.push_back(machine_value);
        for (int i = 0; i < nregs; i++) exp_q.push_back(regs[i]);
        total = exp_q.size();
        widx = 0; k = 0; stall_cnt = 0; first_k = -1; done = 0;
        pv = 0; prdy = 0; ps = '0; pd = '0; pl = 0;
        if (b) start_b = 1'b1; else start_a = 1'b1;
        while (!done) begin
            @(negedge clk);
            k++;
            start_a = 1'b0;
            start_b = 1'b0;
            if (spam_start) begin
                if (b) start_b = 1'($urandom_range(0, 1));
                else   start_a = 1'($urandom_range(0, 1));
            end
            get_out(b, s, d, v, l, bz, h);
            check("busy_in_frame", {31'd0, bz}, 32'd1);
            check("halt_in_frame", {31'd0, h}, 32'd1);
            if (pv && !prdy) begin
                check("stall_valid", {31'd0, v}, 32'd1);
                check("stall_data", d, pd);
                check("stall_last", {31'd0, l}, {31'd0, pl});
                check("stall_sel", {28'd0, s}, {28'd0, ps});
            end
            if (v && first_k < 0) begin
                first_k = k;
                check("first_valid_cycle", k, hdr ? 32'd1 : 32'd2);
            end
            if (v) begin
                if (widx == stall_word && stall_cnt < 5) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end else if (rand_ready) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end else begin
                    out_ready = 1'b1;
                end
                if (out_ready) begin
                    $display("word %0d data=%h last=%0d cycle=%0d", widx, d, l, k);
                    check("word_data", d, exp_q[widx]);
                    check("word_last", {31'd0, l}, (widx == total - 1) ? 32'd1 : 32'd0);
                    if (widx >= int'(hdr))
                        check("word_sel", {28'd0, s}, widx - int'(hdr));
                    widx++;
                    if (widx == total) done = 1;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            pv = v; prdy = out_ready; pd = d; pl = l; ps = s;
            corrupt = v ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!done && k > 600) begin
                check("frame_timeout", widx, total);
                done = 1;
            end
        end
        if (exp_cycles > 0) check("frame_cycles", k, exp_cycles);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        corrupt = 1'b0;
        out_ready = 1'b1;
        get_out(b, s, d, v, l, bz, h);
        check("busy_fall", {31'd0, bz}, 32'd0);
        check("halt_fall", {31'd0, h}, 32'd0);
        check("valid_after", {31'd0, v}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            get_out(b, s, d, v, l, bz, h);
            check("no_extra_word", {31'd0, v}, 32'd0);
        end
    endtask

    initial begin
        int  k;
        bit  found;
        reset_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        out_ready = 1'b1;
        corrupt = 1'b0;
        machine_value = 32'hE281_0001;
        for (int i = 0; i < 16; i++) regs[i] = 32'h100 + i;
        repeat (2) @(negedge clk);
        check("rst_sel", {28'd0, a_sel}, 32'd0);
        check("rst_data", a_data, 32'd0);
        check("rst_valid", {31'd0, a_valid}, 32'd0);
        check("rst_last", {31'd0, a_last}, 32'd0);
        check("rst_busy", {31'd0, a_busy}, 32'd0);
        check("rst_halt", {31'd0, a_halt}, 32'd0);
        check("rst_b_valid", {31'd0, b_valid}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Reference frame with known contents and a free-running consumer.
        run_frame(1'b0, 16, 1'b1, -1, 1'b0, 1'b0, 33);

        // Five-cycle backpressure on word 3.
        randomize_regs();
        run_frame(1'b0, 16, 1'b1, 3, 1'b0, 1'b0, 0);

        // Repeated start while busy yields one frame; a later start yields another.
        randomize_regs();
        run_frame(1'b0, 16, 1'b1, -1, 1'b1, 1'b1, 0);
        randomize_regs();
        run_frame(1'b0, 16, 1'b1, -1, 1'b0, 1'b0, 33);

        // Reset while R7 is on the output.
        randomize_regs();
        start_a = 1'b1;
        found = 0;
        k = 0;
        while (!found && k < 100) begin
            @(negedge clk);
            start_a = 1'b0;
            out_ready = 1'b1;
            k++;
            if (a_valid && a_sel == 4'd7 && a_data == regs[7]) found = 1;
        end
        check("r7_reached", {31'd0, found}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_sel", {28'd0, a_sel}, 32'd0);
        check("abort_data", a_data, 32'd0);
        check("abort_valid", {31'd0, a_valid}, 32'd0);
        check("abort_last", {31'd0, a_last}, 32'd0);
        check("abort_busy", {31'd0, a_busy}, 32'd0);
        check("abort_halt", {31'd0, a_halt}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        randomize_regs();
        run_frame(1'b0, 16, 1'b1, -1, 1'b0, 1'b0, 33);

        // Headerless four-register variant.
        randomize_regs();
        run_frame(1'b1, 4, 1'b0, -1, 1'b0, 1'b0, 8);
        randomize_regs();
        run_frame(1'b1, 4, 1'b0, 1, 1'b1, 1'b1, 0);

        // Random contents under a random consumer.
        for (int r = 0; r < 4; r++) begin
            randomize_regs();
            run_frame(1'b0, 16, 1'b1, -1, 1'b1, 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
